mem_ctrl: RTL and testbench

- Bus-side access sequencer placed directly upstream of the 256x8 RAM; sole driver of its address, we, oe and the shared tri-state data bus.
- Turns single-cycle request/response transactions from the CPU control unit into correctly timed RAM cycles: single read, single write, and block copy (DMA-style memmove-forward).
- Hides the RAM's registered read (data is loaded into the RAM's output buffer on the clock edge and driven only while oe=1 and we=0) and guarantees bus turnaround.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM access sequencer and the 256x8 RAM it fronts.
package mem_pkg;
  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_COPY  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR, CP_A, CP_D, CP_W
  } state_e;
endpackage

// File: rtl/mem_ctrl.sv
// RAM access sequencer: single read, single write and forward block copy
// against a registered-read RAM on a shared tri-state data bus.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_dst,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_oe,
  inout  wire  [DW-1:0] mem_data
);

  state_e        state;
  logic [AW-1:0] src, dst, cnt;
  logic [DW-1:0] dout;   // write data, or the byte in flight during a copy
  logic          drv;

  assign req_ready = (state == IDLE);
  assign mem_data  = drv ? dout : {DW{1'bz}};

  // All bus-facing controls are registered and change together on the same
  // edge, so oe drops exactly when the write drive starts (and vice versa).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      dout      <= '0;
      drv       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          src  <= req_addr;
          dst  <= req_dst;
          cnt  <= req_len;
          dout <= req_wdata;
          case (req_op)
            OP_READ: begin
              mem_addr <= req_addr;
              state    <= RD_A;
            end
            OP_WRITE: begin
              mem_addr <= req_addr;
              mem_we   <= 1'b1;
              drv      <= 1'b1;
              state    <= WR;
            end
            OP_COPY: begin
              if (req_len != '0) begin
                mem_addr <= req_addr;
                state    <= CP_A;
              end else begin
                rsp_valid <= 1'b1;
              end
            end
            default: begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          endcase
        end
        RD_A: begin
          mem_oe <= 1'b1;
          state  <= RD_D;
        end
        RD_D: begin
          mem_oe    <= 1'b0;
          rsp_rdata <= mem_data;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        WR: begin
          mem_we    <= 1'b0;
          drv       <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        CP_A: begin
          mem_oe <= 1'b1;
          state  <= CP_D;
        end
        CP_D: begin
          mem_oe   <= 1'b0;
          dout     <= mem_data;
          mem_addr <= dst;
          mem_we   <= 1'b1;
          drv      <= 1'b1;
          state    <= CP_W;
        end
        CP_W: begin
          mem_we <= 1'b0;
          drv    <= 1'b0;
          src    <= src + AW'(1);
          dst    <= dst + AW'(1);
          cnt    <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            mem_addr <= src + AW'(1);
            state    <= CP_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: registered-read RAM model, transaction-level
// shadow memory, directed vector table, reset/backpressure sequences, random ops.
module tb_mem_ctrl;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_addr = '0, req_dst = '0, req_len = '0, req_wdata = '0;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata, mem_addr;
  logic       mem_we, mem_oe;
  wire  [7:0] mem_data;

  mem_ctrl #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // RAM model: buffer loaded on every edge, driven only while oe=1 and we=0
  logic [7:0] ram  [256];
  logic [7:0] refm [256];
  logic [7:0] rbuf = '0;
  assign mem_data = (mem_oe && !mem_we) ? rbuf : 8'hzz;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    rbuf <= ram[mem_addr];
  end

  int checks = 0, failures = 0;
  int we_cnt = 0, oe_cnt = 0, viol = 0;
  always @(negedge clk) if (reset_n) begin
    if (mem_we) we_cnt++;
    if (mem_oe) oe_cnt++;
    if (mem_we && mem_oe) viol++;
    if (mem_oe && mem_data !== rbuf) viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op, input logic [7:0] len);
    case (op)
      OP_READ:  return 3;
      OP_WRITE: return 2;
      OP_COPY:  return (len == 0) ? 1 : 3 * int'(len) + 1;
      default:  return 1;
    endcase
  endfunction

  task automatic do_req(input logic [1:0] op, input logic [7:0] a, d, l, w,
                        input int exp_lat, input logic exp_err,
                        input logic [7:0] exp_rd, input string nm);
    int n, lat, we0, oe0, v0, exp_we, exp_oe;
    logic [7:0] rd0;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    rd0 = rsp_rdata; we0 = we_cnt; oe0 = oe_cnt; v0 = viol;
    req_op = op; req_addr = a; req_dst = d; req_len = l; req_wdata = w; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_err"}, rsp_err, exp_err);
    if (op == OP_READ) chk({nm, "_rdata"}, rsp_rdata, exp_rd);
    else               chk({nm, "_rdata_hold"}, rsp_rdata, rd0);
    exp_we = (op == OP_WRITE) ? 1 : (op == OP_COPY) ? int'(l) : 0;
    exp_oe = (op == OP_READ)  ? 1 : (op == OP_COPY) ? int'(l) : 0;
    chk({nm, "_we_cycles"}, we_cnt - we0, exp_we);
    chk({nm, "_oe_cycles"}, oe_cnt - oe0, exp_oe);
    chk({nm, "_bus_rules"}, viol - v0, 0);
    case (op)
      OP_WRITE: refm[a] = w;
      OP_COPY:  for (int i = 0; i < int'(l); i++) refm[(int'(d) + i) % 256] = refm[(int'(a) + i) % 256];
      default: ;
    endcase
    @(posedge clk); #1;
    chk({nm, "_single_pulse"}, rsp_valid, 1'b0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr, dst, len, wdata;
    int         lat;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, d, l, w,
                              input int lat, input logic err, input logic [7:0] rd);
    vec_t v;
    v.op = op; v.addr = a; v.dst = d; v.len = l; v.wdata = w;
    v.lat = lat; v.err = err; v.rdata = rd;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int acc, pulses, last, cyc, mism;
    logic acc_now;
    logic [1:0] rop;
    logic [7:0] ra, rd, rl, rw;
    int r;

    for (int i = 0; i < 256; i++) begin
      ram[i]  = 8'($urandom);
      refm[i] = ram[i];
    end

    // power-on reset
    #1 reset_n = 1'b0;
    #20 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err",   rsp_err,   1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_mem_addr",  mem_addr,  8'h00);
    chk("rst_mem_we",    mem_we,    1'b0);
    chk("rst_mem_oe",    mem_oe,    1'b0);

    // reset in the middle of a copy: byte 0 written, byte 1 in its read phase
    req_op = OP_COPY; req_addr = 8'h10; req_dst = 8'h20; req_len = 8'd8; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midcopy_oe_before_reset", mem_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_we",    mem_we,    1'b0);
    chk("midrst_mem_oe",    mem_oe,    1'b0);
    chk("midrst_mem_addr",  mem_addr,  8'h00);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_rsp_rdata", rsp_rdata, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    refm[8'h20] = refm[8'h10];
    @(posedge clk); #1;
    chk("midrst_no_rsp", rsp_valid, 1'b0);
    chk("midrst_ready",  req_ready, 1'b1);
    do_req(OP_READ, 8'h20, 8'h00, 8'h00, 8'h00, 3, 1'b0, refm[8'h20], "midrst_rd20");
    do_req(OP_READ, 8'h22, 8'h00, 8'h00, 8'h00, 3, 1'b0, refm[8'h22], "midrst_rd22");

    // directed vector table
    vecs.push_back(mk(OP_WRITE, 8'h3C, 8'h00, 8'h00, 8'h5A, 2,  1'b0, 8'h00));
    vecs.push_back(mk(OP_READ,  8'h3C, 8'h00, 8'h00, 8'h00, 3,  1'b0, 8'h5A));
    vecs.push_back(mk(OP_WRITE, 8'hFE, 8'h00, 8'h00, 8'h11, 2,  1'b0, 8'h00));
    vecs.push_back(mk(OP_WRITE, 8'hFF, 8'h00, 8'h00, 8'h22, 2,  1'b0, 8'h00));
    vecs.push_back(mk(OP_WRITE, 8'h00, 8'h00, 8'h00, 8'h33, 2,  1'b0, 8'h00));
    vecs.push_back(mk(OP_COPY,  8'hFE, 8'h40, 8'd3,  8'h00, 10, 1'b0, 8'h00));
    vecs.push_back(mk(OP_READ,  8'h40, 8'h00, 8'h00, 8'h00, 3,  1'b0, 8'h11));
    vecs.push_back(mk(OP_READ,  8'h41, 8'h00, 8'h00, 8'h00, 3,  1'b0, 8'h22));
    vecs.push_back(mk(OP_READ,  8'h42, 8'h00, 8'h00, 8'h00, 3,  1'b0, 8'h33));
    vecs.push_back(mk(OP_WRITE, 8'h80, 8'h00, 8'h00, 8'hAA, 2,  1'b0, 8'h00));
    vecs.push_back(mk(OP_COPY,  8'h80, 8'h81, 8'd4,  8'h00, 13, 1'b0, 8'h00));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(OP_READ, 8'(8'h80 + i), 8'h00, 8'h00, 8'h00, 3, 1'b0, 8'hAA));
    vecs.push_back(mk(OP_COPY,  8'h10, 8'h90, 8'd0,  8'h00, 1,  1'b0, 8'h00));
    vecs.push_back(mk(OP_RSVD,  8'h33, 8'h44, 8'd5,  8'h77, 1,  1'b1, 8'h00));
    vecs.push_back(mk(OP_READ,  8'h3C, 8'h00, 8'h00, 8'h00, 3,  1'b0, 8'h5A));
    foreach (vecs[i])
      do_req(vecs[i].op, vecs[i].addr, vecs[i].dst, vecs[i].len, vecs[i].wdata,
             vecs[i].lat, vecs[i].err, vecs[i].rdata, $sformatf("vec%0d", i));

    // back-to-back reads with req_valid held high
    req_op = OP_READ; req_addr = 8'h00; req_valid = 1'b1;
    acc = 0; pulses = 0; last = 0; cyc = 0;
    while (pulses < 4 && cyc < 60) begin
      acc_now = req_valid && req_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        if (acc > 0) chk("bp_accept_spacing", cyc - last, 3);
        last = cyc;
        acc++;
        chk("bp_ready_low", req_ready, 1'b0);
        if (acc < 4) req_addr = acc[7:0];
        else req_valid = 1'b0;
      end else if (!rsp_valid) begin
        chk("bp_ready_low_rd", req_ready, 1'b0);
      end
      if (rsp_valid) begin
        chk($sformatf("bp_rdata%0d", pulses), rsp_rdata, refm[pulses]);
        pulses++;
      end
    end
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk("bp_pulses", pulses, 4);
    chk("bp_accepts", acc, 4);

    // randomized ops against the shadow memory
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      rop = (r < 3) ? OP_READ : (r < 6) ? OP_WRITE : (r < 9) ? OP_COPY : OP_RSVD;
      ra = 8'($urandom); rd = 8'($urandom); rw = 8'($urandom);
      rl = 8'($urandom_range(0, 6));
      do_req(rop, ra, rd, rl, rw, lat_of(rop, rl), rop == OP_RSVD, refm[ra],
             $sformatf("rnd%0d", k));
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== refm[i]) mism++;
    chk("ram_image_mismatches", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
